// File: rtl/loop_replay_buf.sv
// Loop replay buffer: records a loop body from fetch, then replays it in up-to-4-wide
// groups until the final unroll completes, a mis-predict flushes it, or reset.
// state  | meaning
// IDLE   | fetch pass-through; 2'b11 decodes here too
// RECORD | pass-through while capturing valid slots into storage
// REPLAY | issue recorded entries, wrapping at wr_cnt
module loop_replay_buf #(
  parameter int DEPTH = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] inst_in,
  input  logic [63:0] pc_in,
  input  logic [3:0]  inst_valid_in,
  input  logic        loop_strt_in,
  input  logic        stll_ftch_in,
  input  logic        fnsh_unrll_in,
  input  logic        mis_pred_in,
  input  logic        stall_in,
  output logic [63:0] inst_out,
  output logic [63:0] pc_out,
  output logic [3:0]  inst_valid_out,
  output logic [$clog2(DEPTH):0] buf_cnt_out,
  output logic        replay_out,
  output logic        ovf_out
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [1:0] S_IDLE = 2'b00, S_RECORD = 2'b01, S_REPLAY = 2'b10;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] wr_cnt_q, wr_cnt_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic          fin_lat_q, fin_lat_d;
  logic [63:0]   inst_q, inst_d, pc_q, pc_d;
  logic [3:0]    valid_q, valid_d;
  logic          replay_q, ovf_q, ovf_d;
  logic          we;
  logic [AW-1:0] wr_base;

  logic [31:0]   mem_q [DEPTH];
  logic [31:0]   rd_word [4];
  logic [2:0]    n_in, k;
  logic [CW-1:0] wr_sum, rem, rd_sum;
  logic          ovf_hit, wrap, fin_now;

  function automatic logic [3:0] pmask(input logic [2:0] n);
    return {n >= 3'd1, n >= 3'd2, n >= 3'd3, n >= 3'd4};
  endfunction

  always_comb begin
    casez (inst_valid_in)
      4'b0???: n_in = 3'd0;
      4'b10??: n_in = 3'd1;
      4'b110?: n_in = 3'd2;
      4'b1110: n_in = 3'd3;
      default: n_in = 3'd4;
    endcase
  end

  assign wr_sum  = wr_cnt_q + CW'(n_in);
  assign ovf_hit = wr_sum > CW'(DEPTH);
  assign rem     = wr_cnt_q - CW'(rd_ptr_q);
  assign k       = (rem >= CW'(4)) ? 3'd4 : rem[2:0];
  assign rd_sum  = CW'(rd_ptr_q) + CW'(k);
  assign wrap    = (rd_sum == wr_cnt_q);
  assign fin_now = fin_lat_q | fnsh_unrll_in;

  always_comb begin
    for (int s = 0; s < 4; s++) rd_word[s] = mem_q[rd_ptr_q + AW'(s)];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (mis_pred_in) begin
      state_d = S_IDLE;
    end else if (!stall_in) begin
      case (state_q)
        S_RECORD: begin
          if (ovf_hit)                         state_d = S_IDLE;
          else if (stll_ftch_in)               state_d = (wr_sum != '0) ? S_REPLAY : S_IDLE;
        end
        S_REPLAY: if (wrap && fin_now)         state_d = S_IDLE;
        default:  state_d = loop_strt_in ? S_RECORD : S_IDLE;
      endcase
    end
  end

  always_comb begin
    wr_cnt_d  = wr_cnt_q;
    rd_ptr_d  = rd_ptr_q;
    fin_lat_d = fin_lat_q;
    inst_d    = inst_q;
    pc_d      = pc_q;
    valid_d   = valid_q;
    ovf_d     = 1'b0;
    we        = 1'b0;
    wr_base   = wr_cnt_q[AW-1:0];
    if (mis_pred_in) begin
      wr_cnt_d  = '0;
      rd_ptr_d  = '0;
      fin_lat_d = 1'b0;
      valid_d   = 4'b0000;
    end else if (!stall_in) begin
      case (state_q)
        S_REPLAY: begin
          inst_d  = '0;
          pc_d    = '0;
          valid_d = pmask(k);
          for (int s = 0; s < 4; s++) begin
            if (3'(s) < k) begin
              inst_d[63-16*s -: 16] = rd_word[s][31:16];
              pc_d[63-16*s -: 16]   = rd_word[s][15:0];
            end
          end
          fin_lat_d = fin_now;
          if (wrap) begin
            rd_ptr_d = '0;
            if (fin_now) begin
              fin_lat_d = 1'b0;
              wr_cnt_d  = '0;
            end
          end else begin
            rd_ptr_d = rd_sum[AW-1:0];
          end
        end
        S_RECORD: begin
          inst_d  = inst_in;
          pc_d    = pc_in;
          valid_d = pmask(n_in);
          if (ovf_hit) begin
            ovf_d    = 1'b1;
            wr_cnt_d = '0;
          end else begin
            we       = 1'b1;
            wr_cnt_d = wr_sum;
            if (stll_ftch_in) begin
              rd_ptr_d  = '0;
              fin_lat_d = 1'b0;
            end
          end
        end
        default: begin
          inst_d  = inst_in;
          pc_d    = pc_in;
          valid_d = pmask(n_in);
          if (loop_strt_in) begin
            we        = 1'b1;
            wr_base   = '0;
            wr_cnt_d  = CW'(n_in);
            rd_ptr_d  = '0;
            fin_lat_d = 1'b0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt_q  <= '0;
      rd_ptr_q  <= '0;
      fin_lat_q <= 1'b0;
      inst_q    <= '0;
      pc_q      <= '0;
      valid_q   <= 4'b0000;
      replay_q  <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      wr_cnt_q  <= wr_cnt_d;
      rd_ptr_q  <= rd_ptr_d;
      fin_lat_q <= fin_lat_d;
      inst_q    <= inst_d;
      pc_q      <= pc_d;
      valid_q   <= valid_d;
      replay_q  <= (state_d == S_REPLAY);
      ovf_q     <= ovf_d;
    end
  end

  // Storage is deliberately unreset; the replay mask keeps unwritten entries off the outputs.
  always_ff @(posedge clk) begin
    if (we) begin
      if (n_in >= 3'd1) mem_q[wr_base]           <= {inst_in[63:48], pc_in[63:48]};
      if (n_in >= 3'd2) mem_q[wr_base + AW'(1)] <= {inst_in[47:32], pc_in[47:32]};
      if (n_in >= 3'd3) mem_q[wr_base + AW'(2)] <= {inst_in[31:16], pc_in[31:16]};
      if (n_in >= 3'd4) mem_q[wr_base + AW'(3)] <= {inst_in[15:0],  pc_in[15:0]};
    end
  end

  assign inst_out       = inst_q;
  assign pc_out         = pc_q;
  assign inst_valid_out = valid_q;
  assign buf_cnt_out    = wr_cnt_q;
  assign replay_out     = replay_q;
  assign ovf_out        = ovf_q;
endmodule

// File: tb/tb_loop_replay_buf.sv
// Directed bench for loop_replay_buf: expected outputs are queued as each cycle is
// driven and popped for comparison one cycle later.
module tb_loop_replay_buf;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] inst_in, pc_in, inst_out, pc_out;
  logic [3:0]  inst_valid_in, inst_valid_out;
  logic        loop_strt_in, stll_ftch_in, fnsh_unrll_in, mis_pred_in, stall_in;
  logic [6:0]  buf_cnt_out;
  logic        replay_out, ovf_out;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string       tag;
    logic [3:0]  v;
    logic [63:0] inst;
    logic [63:0] pc;
    logic        cd;
    logic [6:0]  cnt;
    logic        rep;
    logic        ovf;
  } exp_t;
  exp_t sb[$];

  loop_replay_buf #(.DEPTH(64)) dut (
    .clk(clk), .rst_n(rst_n), .inst_in(inst_in), .pc_in(pc_in),
    .inst_valid_in(inst_valid_in), .loop_strt_in(loop_strt_in),
    .stll_ftch_in(stll_ftch_in), .fnsh_unrll_in(fnsh_unrll_in),
    .mis_pred_in(mis_pred_in), .stall_in(stall_in), .inst_out(inst_out),
    .pc_out(pc_out), .inst_valid_out(inst_valid_out), .buf_cnt_out(buf_cnt_out),
    .replay_out(replay_out), .ovf_out(ovf_out)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] gi(input int g);
    logic [15:0] b;
    b = 16'hA000 + 16'(4 * g);
    return {b, b + 16'd1, b + 16'd2, b + 16'd3};
  endfunction

  function automatic logic [63:0] gp(input int g);
    logic [15:0] b;
    b = 16'h1000 + 16'(4 * g);
    return {b, b + 16'd1, b + 16'd2, b + 16'd3};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag, input logic [3:0] vin, input logic [63:0] iin,
                      input logic [63:0] pin, input logic ls, input logic sf, input logic fu,
                      input logic mp, input logic st, input logic [3:0] ev,
                      input logic [63:0] ei, input logic [63:0] ep, input logic cd,
                      input logic [6:0] ec, input logic er, input logic eo);
    exp_t e;
    inst_valid_in = vin; inst_in = iin; pc_in = pin;
    loop_strt_in = ls; stll_ftch_in = sf; fnsh_unrll_in = fu;
    mis_pred_in = mp; stall_in = st;
    sb.push_back('{tag, ev, ei, ep, cd, ec, er, eo});
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s observed=empty_queue expected=entry", tag);
    end else begin
      e = sb.pop_front();
      chk({e.tag, ".valid"}, 64'(inst_valid_out), 64'(e.v));
      if (e.cd) begin
        chk({e.tag, ".inst"}, inst_out, e.inst);
        chk({e.tag, ".pc"}, pc_out, e.pc);
      end
      chk({e.tag, ".cnt"}, 64'(buf_cnt_out), 64'(e.cnt));
      chk({e.tag, ".replay"}, 64'(replay_out), 64'(e.rep));
      chk({e.tag, ".ovf"}, 64'(ovf_out), 64'(e.ovf));
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".inst"}, inst_out, 64'd0);
    chk({tag, ".pc"}, pc_out, 64'd0);
    chk({tag, ".valid"}, 64'(inst_valid_out), 64'd0);
    chk({tag, ".cnt"}, 64'(buf_cnt_out), 64'd0);
    chk({tag, ".replay"}, 64'(replay_out), 64'd0);
    chk({tag, ".ovf"}, 64'(ovf_out), 64'd0);
  endtask

  initial begin
    logic [63:0] p2i, p2p, r2i, r2p, m1i, m1p;
    rst_n = 1'b0;
    inst_in = '0; pc_in = '0; inst_valid_in = '0;
    loop_strt_in = 0; stll_ftch_in = 0; fnsh_unrll_in = 0; mis_pred_in = 0; stall_in = 0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    rst_n = 1'b1;

    // pass-through
    step("pass", 4'b1111, 64'h1111_2222_3333_4444, gp(40), 0, 0, 0, 0, 0,
         4'b1111, 64'h1111_2222_3333_4444, gp(40), 1, 7'd0, 0, 0);
    step("pass_part", 4'b1011, gi(41), gp(41), 0, 0, 0, 0, 0,
         4'b1000, gi(41), gp(41), 1, 7'd0, 0, 0);

    // record 10 entries, replay, finish during second group of a pass
    p2i = 64'hA008_A009_DEAD_BEEF; p2p = 64'h1008_1009_0BAD_0BAD;
    r2i = 64'hA008_A009_0000_0000; r2p = 64'h1008_1009_0000_0000;
    step("rec0", 4'b1111, gi(0), gp(0), 1, 0, 0, 0, 0, 4'b1111, gi(0), gp(0), 1, 7'd4, 0, 0);
    step("rec1", 4'b1111, gi(1), gp(1), 0, 0, 0, 0, 0, 4'b1111, gi(1), gp(1), 1, 7'd8, 0, 0);
    step("rec2", 4'b1100, p2i, p2p, 0, 1, 0, 0, 0, 4'b1100, p2i, p2p, 1, 7'd10, 1, 0);
    step("rp0", 4'b0000, '0, '0, 0, 0, 0, 0, 0, 4'b1111, gi(0), gp(0), 1, 7'd10, 1, 0);
    step("rp_stall", 4'b1111, gi(9), gp(9), 0, 0, 0, 0, 1, 4'b1111, gi(0), gp(0), 1, 7'd10, 1, 0);
    step("rp1", 4'b0000, '0, '0, 0, 0, 0, 0, 0, 4'b1111, gi(1), gp(1), 1, 7'd10, 1, 0);
    step("rp2", 4'b0000, '0, '0, 0, 0, 0, 0, 0, 4'b1100, r2i, r2p, 1, 7'd10, 1, 0);
    step("rp0b", 4'b0000, '0, '0, 0, 0, 0, 0, 0, 4'b1111, gi(0), gp(0), 1, 7'd10, 1, 0);
    step("rp1_fin", 4'b0000, '0, '0, 0, 0, 1, 0, 0, 4'b1111, gi(1), gp(1), 1, 7'd10, 1, 0);
    step("rp2_last", 4'b0000, '0, '0, 0, 0, 0, 0, 0, 4'b1100, r2i, r2p, 1, 7'd0, 0, 0);
    step("idle_after", 4'b0000, '0, '0, 0, 0, 0, 0, 0, 4'b0000, '0, '0, 1, 7'd0, 0, 0);

    // overflow: exactly 64 fits, the 65th entry overflows
    for (int g = 0; g < 16; g++)
      step($sformatf("fill%0d", g), 4'b1111, gi(g), gp(g), (g == 0), 0, 0, 0, 0,
           4'b1111, gi(g), gp(g), 1, 7'(4 * (g + 1)), 0, 0);
    step("ovf", 4'b1000, gi(20), gp(20), 0, 0, 0, 0, 0, 4'b1000, gi(20), gp(20), 1, 7'd0, 0, 1);
    step("ovf_idle", 4'b1111, gi(21), gp(21), 0, 1, 0, 0, 0, 4'b1111, gi(21), gp(21), 1, 7'd0, 0, 0);

    // simultaneous start+stall-fetch, 7-entry replay, then mis-predict under stall
    m1i = gi(31) & 64'hFFFF_FFFF_FFFF_0000;
    m1p = gp(31) & 64'hFFFF_FFFF_FFFF_0000;
    step("ls_sf", 4'b1111, gi(30), gp(30), 1, 1, 0, 0, 0, 4'b1111, gi(30), gp(30), 1, 7'd4, 0, 0);
    step("rec_1110", 4'b1110, gi(31), gp(31), 0, 1, 0, 0, 0, 4'b1110, gi(31), gp(31), 1, 7'd7, 1, 0);
    step("mrp0", 4'b0000, '0, '0, 0, 0, 0, 0, 0, 4'b1111, gi(30), gp(30), 1, 7'd7, 1, 0);
    step("mrp1", 4'b0000, '0, '0, 0, 0, 0, 0, 0, 4'b1110, m1i, m1p, 1, 7'd7, 1, 0);
    step("mrp0b", 4'b0000, '0, '0, 0, 0, 0, 0, 0, 4'b1111, gi(30), gp(30), 1, 7'd7, 1, 0);
    step("mp_stall", 4'b1111, gi(35), gp(35), 1, 1, 1, 1, 1, 4'b0000, '0, '0, 0, 7'd0, 0, 0);
    step("mp_idle", 4'b1111, gi(32), gp(32), 0, 0, 0, 0, 0, 4'b1111, gi(32), gp(32), 1, 7'd0, 0, 0);

    // asynchronous reset in the middle of RECORD
    step("r_rec0", 4'b1111, gi(33), gp(33), 1, 0, 0, 0, 0, 4'b1111, gi(33), gp(33), 1, 7'd4, 0, 0);
    inst_valid_in = 4'b1111; inst_in = gi(36); pc_in = gp(36);
    #2 rst_n = 1'b0;
    #1 chk_zero("async_rst");
    @(posedge clk);
    #1 rst_n = 1'b1;
    step("r_after", 4'b1111, gi(34), gp(34), 0, 1, 0, 0, 0, 4'b1111, gi(34), gp(34), 1, 7'd0, 0, 0);
    step("r_after2", 4'b0000, '0, '0, 0, 0, 0, 0, 0, 4'b0000, '0, '0, 1, 7'd0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/loop_replay_buf.md
LOOP_REPLAY_BUF -- requirements
Module: loop_replay_buf

Interface
REQ-001 SHALL have parameter DEPTH, default 64, meaning loop-body entry capacity; the counts, the full test and every boundary below are stated for DEPTH=64.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port inst_in, input, 64, four 16-bit instructions from fetch, slot0 = [63:48].
REQ-005 SHALL have port pc_in, input, 64, four 16-bit PCs matching inst_in slots.
REQ-006 SHALL have port inst_valid_in, input, 4, per-slot valid from the loop detector, bit3 = slot0.
REQ-007 SHALL have port loop_strt_in, input, 1, the current fetch group starts a known loop.
REQ-008 SHALL have port stll_ftch_in, input, 1, fetch is stalled (loop body complete).
REQ-009 SHALL have port fnsh_unrll_in, input, 1, the last unroll is issued.
REQ-010 SHALL have port mis_pred_in, input, 1, flush.
REQ-011 SHALL have port stall_in, input, 1, downstream cannot accept this cycle.
REQ-012 SHALL have port inst_out, output, 64, four instructions to decode.
REQ-013 SHALL have port pc_out, output, 64, matching PCs.
REQ-014 SHALL have port inst_valid_out, output, 4, per-slot valid, prefix form.
REQ-015 SHALL have port buf_cnt_out, output, 7, number of recorded entries.
REQ-016 SHALL have port replay_out, output, 1, high while in REPLAY.
REQ-017 SHALL have port ovf_out, output, 1, one-cycle pulse on a record overflow.

Function
REQ-018 SHALL have storage of DEPTH entries of {inst[15:0], pc[15:0]}, plus wr_cnt (7b), rd_ptr (6b), fin_lat (1b).
REQ-019 SHALL implement a 3-state FSM with IDLE=2'b00, RECORD=2'b01, REPLAY=2'b10; 2'b11 SHALL be treated as IDLE.
REQ-020 SHALL define n_in as the count of consecutive ones in inst_valid_in starting from bit3 (e.g. 4'b1011 -> 1).
REQ-021 SHALL, in IDLE and RECORD with stall_in=0, register the inputs to the outputs with 1-cycle latency, with inst_valid_out = prefix mask of n_in.
REQ-022 SHALL, whenever stall_in=1, hold all outputs and make no change to the pointers or wr_cnt; the FSM SHALL still act on mis_pred_in.
REQ-023 SHALL make the IDLE->RECORD transition on loop_strt_in=1 with stall_in=0; wr_cnt SHALL restart at 0, and that same group SHALL be written.
REQ-024 SHALL, in RECORD, write the n_in valid slots to entries wr_cnt..wr_cnt+n_in-1 in slot order, then set wr_cnt += n_in.
REQ-025 SHALL, if wr_cnt+n_in > 64, write nothing, pulse ovf_out, and go to IDLE with wr_cnt=0.
REQ-026 SHALL make the RECORD->REPLAY transition on stll_ftch_in=1 with wr_cnt>0, after the same-cycle write; rd_ptr SHALL be set to 0; with wr_cnt=0 the block SHALL go to IDLE.
REQ-027 SHALL, in REPLAY, ignore fetch inputs and, per unstalled cycle, emit entries rd_ptr..rd_ptr+k-1 with k = min(4, wr_cnt-rd_ptr) and inst_valid_out = prefix mask of k.
REQ-028 SHALL advance rd_ptr by k, wrapping to 0 when rd_ptr+k = wr_cnt; a replay group SHALL never span the wrap (a pass boundary always ends a group).
REQ-029 SHALL set fin_lat when fnsh_unrll_in=1 in REPLAY; at the first wrap with fin_lat set (including a same-cycle fnsh_unrll_in), the block SHALL go to IDLE and clear fin_lat and wr_cnt.
REQ-030 SHALL, on mis_pred_in=1 in any state, go to IDLE next edge, clear wr_cnt, rd_ptr and fin_lat, and drive inst_valid_out=4'b0000 next cycle; it SHALL take priority over all other inputs.
REQ-031 SHALL drive buf_cnt_out = wr_cnt and replay_out = (state==REPLAY), both registered.
REQ-032 SHALL give simultaneous loop_strt_in and stll_ftch_in in IDLE the IDLE->RECORD transition only.

Reset
REQ-033 SHALL, on rst_n=0, asynchronously set state=IDLE, wr_cnt=0, rd_ptr=0, fin_lat=0, inst_out=0, pc_out=0, inst_valid_out=4'b0000, replay_out=0, ovf_out=0.
REQ-034 SHALL leave storage contents uninitialised at reset, and SHALL never output storage that has not been written.
REQ-035 SHALL abandon any RECORD or REPLAY in progress when reset is asserted; the first valid output after release SHALL come from fetch.

Verification
REQ-036 SHALL verify pass-through: IDLE, valid 4'b1111, inst 0x1111_2222_3333_4444 -> same inst_out and valid one cycle later.
REQ-037 SHALL verify record then replay: record 1111, 1111, 1100 (10 entries), then stll_ftch_in -> buf_cnt_out=10 and replay groups with masks 1111, 1111, 1100, repeating.
REQ-038 SHALL verify finish: fnsh_unrll_in during the second replay group -> the third group (1100) is emitted, then IDLE, replay_out=0.
REQ-039 SHALL verify overflow: 16 groups of 1111 (64) then 1000 -> ovf_out pulses, state IDLE, buf_cnt_out=0.
REQ-040 SHALL verify mis-predict: mis_pred_in with stall_in=1 mid-replay -> next cycle IDLE, inst_valid_out=0000.
REQ-041 SHALL verify reset: rst_n low mid-RECORD -> all outputs zero immediately, without waiting for a clock edge.
